load_store_unit: RTL and testbench

//  Memory-side counterpart of the control stage: consumes mem read/write enables, load size and

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   lsu_state_e   : FSM state encoding (IDLE, BUSY, DONE)
//   SZ_*          : size codes from the decoder (3 aliases to byte)
//   be_for()      : byte-enable pattern for a size / low address bits
//   is_misaligned(): true when a half/word access is not naturally aligned
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size code 3 falls through to the byte pattern.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0001 << lo;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Data-memory req/ack bus between the load/store unit (master) and memory
// (slave).
//   mem_req   : request, held high until the cycle mem_ack is seen
//   mem_we    : 1 = write
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables
//   mem_wdata : lane-replicated store data
//   mem_ack   : completion; mem_rdata is valid in the same cycle
//   mem_rdata : raw word read data
// Handshake: a transfer completes in the cycle where mem_req and mem_ack are
// both high; the master keeps every request field stable until then and may
// abandon a request only on reset or timeout.
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Combinational byte-lane steering.
//   size_i     : access size code
//   addr_lo_i  : byte address bits [1:0]
//   unsigned_i : zero-extend loads when 1
//   wdata_i    : store data from the register file
//   rdata_i    : raw word from memory
//   wdata_o    : store data replicated across all lanes
//   rdata_o    : selected lane, sign/zero extended to 32 bits
// Half accesses use addr[1] only and word accesses ignore the low bits, so
// misaligned addresses resolve to the containing aligned lane.
// ---------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wdata_o  = {4{wdata_i[7:0]}};
        rdata_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        case (size_i)
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Runs one data-memory transaction per load/store op from the control stage,
// steers byte lanes, extends load data and stalls the pipeline meanwhile.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined     : misaligned half/word ops complete immediately with err_o=1,
//                 rdata_o=0 and no bus access
//   not defined : low address bits beyond the access size are ignored
//
// Parameters: ADDR_W (byte address width), TIMEOUT_CYC (BUSY cycles without
// ack before the op is aborted, >= 2).
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rd_en_i       : load request (level, held while stall_o=1)
//   wr_en_i       : store request (level, held while stall_o=1)
//   size_i        : 0=byte 1=half 2=word 3=byte
//   unsigned_i    : zero-extend loads
//   addr_i        : effective byte address
//   wdata_i       : store data
//   stall_o       : hold the pipeline
//   done_o        : one-cycle pulse when the op finishes
//   err_o         : one-cycle pulse with done_o on error
//   rdata_o       : extended load data, held until the next done_o
//   dbg_state_o   : current FSM state (lsu_state_e encoding)
//   mem           : data-memory bus (master side)
//
// Handshake with control: an op is accepted on the rising edge in IDLE where
// rd_en_i or wr_en_i is high; control keeps it stable while stall_o=1 and
// retires it in the cycle done_o is high (stall_o=0 there).
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        dbg_state_o,
    load_store_unit_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              busy;

    lsu_lane_align u_lane_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem.mem_rdata),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        stall_o = 1'b0;

        case (state_q)
            IDLE: begin
                stall_o = rd_en_i | wr_en_i;
                err_d   = 1'b0;
                if (rd_en_i && wr_en_i) begin
                    // Conflicting request: retire with error, bus untouched.
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (rd_en_i || wr_en_i) begin
                    addr_d  = addr_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
                    we_d    = wr_en_i;
                    state_d = BUSY;
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(size_i, addr_i[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (mem.mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus fields come straight from latched state, so they stay stable for
    // the whole BUSY period and fall to zero the cycle after BUSY ends.
    assign busy          = (state_q == BUSY);
    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy & we_q;
    assign mem.mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem.mem_be    = busy ? be_for(size_q, addr_q[1:0]) : 4'b0000;
    assign mem.mem_wdata = busy ? lane_wdata : 32'h0;

    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) & err_q;
    assign rdata_o     = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [1:0]  dbg_state_o;

  int n_chk;
  int n_fail;
  logic [31:0] last_rd;

  load_store_unit_if #(.ADDR_W(32)) mem_bus ();

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en_i     (rd_en_i),
    .wr_en_i     (wr_en_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .dbg_state_o (dbg_state_o),
    .mem         (mem_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raw;
    int          dly;      // BUSY cycles before ack is raised
    logic        bus;      // bus access expected
    logic        we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_err;
    int          rd_mode;  // 0 = check e_rdata, 1 = unchanged, 2 = not checked
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
    rd_en_i    = rd;
    wr_en_i    = wr;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
  endtask

  task automatic idle_inputs();
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
  endtask

  // Applies one table vector; called at posedge+1 with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive_op(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata);
    #1;
    chk({tag, " stall_idle"}, {31'b0, stall_o}, 32'd1);
    step();  // accept edge; now cycle 1
    if (v.bus) begin
      for (int c = 0; c <= v.dly; c++) begin
        chk({tag, " req"}, {31'b0, mem_bus.mem_req}, 32'd1);
        chk({tag, " stall_busy"}, {31'b0, stall_o}, 32'd1);
        if (c == 0) begin
          chk({tag, " we"}, {31'b0, mem_bus.mem_we}, {31'b0, v.we});
          chk({tag, " addr"}, mem_bus.mem_addr, v.e_addr);
          chk({tag, " be"}, {28'b0, mem_bus.mem_be}, {28'b0, v.e_be});
          if (v.we) chk({tag, " wdata"}, mem_bus.mem_wdata, v.e_wdata);
        end
        if (c == v.dly) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = v.raw;
        end
        step();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
      end
    end else begin
      chk({tag, " no_req"}, {31'b0, mem_bus.mem_req}, 32'd0);
    end
    // DONE cycle
    chk({tag, " done"}, {31'b0, done_o}, 32'd1);
    chk({tag, " err"}, {31'b0, err_o}, {31'b0, v.e_err});
    chk({tag, " stall_done"}, {31'b0, stall_o}, 32'd0);
    chk({tag, " req_done"}, {31'b0, mem_bus.mem_req}, 32'd0);
    if (v.rd_mode == 0) begin
      chk({tag, " rdata"}, rdata_o, v.e_rdata);
      last_rd = v.e_rdata;
    end else if (v.rd_mode == 1) begin
      chk({tag, " rdata_kept"}, rdata_o, last_rd);
    end
    idle_inputs();
    step();
    chk({tag, " done_pulse"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    last_rd = 32'h0;
    rst = 1'b1;
    idle_inputs();
    size_i = 2'd0; unsigned_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    //            rd wr sz uns addr        wdata         raw           dly bus we e_addr      e_be     e_wdata       err mode e_rdata
    vecs[0]  = '{1, 0, 0, 0, 32'h103, 32'h0,        32'h80AABBCC, 0, 1, 0, 32'h100, 4'b1000, 32'h0,        0, 0, 32'hFFFFFF80};
    vecs[1]  = '{1, 0, 0, 1, 32'h103, 32'h0,        32'h80AABBCC, 2, 1, 0, 32'h100, 4'b1000, 32'h0,        0, 0, 32'h00000080};
    vecs[2]  = '{1, 0, 3, 0, 32'h101, 32'h0,        32'h11223344, 1, 1, 0, 32'h100, 4'b0010, 32'h0,        0, 0, 32'h00000033};
    vecs[3]  = '{1, 0, 1, 0, 32'h202, 32'h0,        32'h80017FFF, 0, 1, 0, 32'h200, 4'b1100, 32'h0,        0, 0, 32'hFFFF8001};
    vecs[4]  = '{1, 0, 1, 1, 32'h200, 32'h0,        32'h8001F00F, 0, 1, 0, 32'h200, 4'b0011, 32'h0,        0, 0, 32'h0000F00F};
    vecs[5]  = '{1, 0, 1, 0, 32'h200, 32'h0,        32'h1234F00F, 3, 1, 0, 32'h200, 4'b0011, 32'h0,        0, 0, 32'hFFFFF00F};
    vecs[6]  = '{1, 0, 2, 1, 32'h304, 32'h0,        32'h89ABCDEF, 0, 1, 0, 32'h304, 4'b1111, 32'h0,        0, 0, 32'h89ABCDEF};
    vecs[7]  = '{0, 1, 1, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 1, 32'h0};
    vecs[8]  = '{0, 1, 0, 0, 32'h401, 32'hDEADBEEF, 32'h0,        1, 1, 1, 32'h400, 4'b0010, 32'hEFEFEFEF, 0, 1, 32'h0};
    vecs[9]  = '{0, 1, 2, 0, 32'h40C, 32'hCAFEF00D, 32'h0,        0, 1, 1, 32'h40C, 4'b1111, 32'hCAFEF00D, 0, 1, 32'h0};
`ifdef MISALIGN_TRAP_EN
    vecs[10] = '{1, 0, 1, 0, 32'h101, 32'h0,        32'hAAAA5566, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h0};
    vecs[11] = '{1, 0, 2, 0, 32'h103, 32'h0,        32'h11223344, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h0};
`else
    vecs[10] = '{1, 0, 1, 0, 32'h101, 32'h0,        32'hAAAA5566, 0, 1, 0, 32'h100, 4'b0011, 32'h0,        0, 0, 32'h00005566};
    vecs[11] = '{1, 0, 2, 0, 32'h103, 32'h0,        32'h11223344, 0, 1, 0, 32'h100, 4'b1111, 32'h0,        0, 0, 32'h11223344};
`endif
    vecs[12] = '{1, 1, 2, 0, 32'h600, 32'h0,        32'h0,        0, 0, 0, 32'h0,   4'b0000, 32'h0,        1, 2, 32'h0};
    vecs[13] = '{1, 0, 0, 0, 32'h502, 32'h0,        32'h007F0000, 0, 1, 0, 32'h500, 4'b0100, 32'h0,        0, 0, 32'h0000007F};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst state", {30'b0, dbg_state_o}, 32'd0);
    chk("rst stall", {31'b0, stall_o}, 32'd0);
    chk("rst done", {31'b0, done_o}, 32'd0);
    chk("rst err", {31'b0, err_o}, 32'd0);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst req", {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rst be", {28'b0, mem_bus.mem_be}, 32'd0);
    step();

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // timeout: ack withheld for the full 16 BUSY cycles
    drive_op(1, 0, 2'd2, 0, 32'h500, 32'h0);
    step();
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("to req c%0d", c), {31'b0, mem_bus.mem_req}, 32'd1);
      chk($sformatf("to done c%0d", c), {31'b0, done_o}, 32'd0);
      step();
    end
    chk("to req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
    chk("to done", {31'b0, done_o}, 32'd1);
    chk("to err", {31'b0, err_o}, 32'd1);
    chk("to rdata", rdata_o, 32'h0);
    chk("to stall", {31'b0, stall_o}, 32'd0);
    idle_inputs();
    step();
    chk("to done_pulse", {31'b0, done_o}, 32'd0);

    // back-to-back: request held through DONE is only re-accepted from IDLE
    drive_op(1, 0, 2'd2, 0, 32'h700, 32'h0);
    step();  // cycle 1 BUSY
    chk("b2b req1", {31'b0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h0BADF00D;
    step();  // cycle 2 DONE
    mem_bus.mem_ack = 1'b0;
    chk("b2b done1", {31'b0, done_o}, 32'd1);
    chk("b2b rdata1", rdata_o, 32'h0BADF00D);
    drive_op(1, 0, 2'd2, 0, 32'h704, 32'h0);
    step();  // cycle 3 IDLE
    chk("b2b idle_req", {31'b0, mem_bus.mem_req}, 32'd0);
    chk("b2b idle_stall", {31'b0, stall_o}, 32'd1);
    step();  // cycle 4 BUSY
    chk("b2b req2", {31'b0, mem_bus.mem_req}, 32'd1);
    chk("b2b addr2", mem_bus.mem_addr, 32'h704);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h13579BDF;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("b2b done2", {31'b0, done_o}, 32'd1);
    chk("b2b rdata2", rdata_o, 32'h13579BDF);
    idle_inputs();
    step();

    // reset in BUSY cycle 3 abandons the op
    drive_op(1, 0, 2'd2, 0, 32'h800, 32'h0);
    step();
    step();
    step();
    chk("rb req_c3", {31'b0, mem_bus.mem_req}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rb req", {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rb stall", {31'b0, stall_o}, 32'd0);
    chk("rb done", {31'b0, done_o}, 32'd0);
    chk("rb rdata", rdata_o, 32'h0);
    rst = 1'b0;
    step();
    chk("rb done_after", {31'b0, done_o}, 32'd0);
    chk("rb state", {30'b0, dbg_state_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
